// File: rtl/mdio_master_ctrl.sv
// MDIO (Clause 22) management master: serialises one read or write frame per
// accepted request, generating MDC from i_clk and driving/sampling the pad.
module mdio_master_ctrl #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_rw,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic        o_nack,
    output logic        o_mdc,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    input  logic        i_mdio_in
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = (PREAMBLE_LEN > 16) ? $clog2(PREAMBLE_LEN) : 4;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_START, S_OPCODE, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               mdc_q, mdc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               nack_q, nack_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               out_q, out_d;
    logic               oe_q, oe_d;
    logic               rw_q, rw_d;
    logic [31:0]        sr_q, sr_d;
    logic [15:0]        rx_q, rx_d;

    logic accept, tick, rise_tick, fall_tick;

    // Index of the last bit of each field.
    function automatic logic [CNT_W-1:0] last_idx(input state_t s);
        case (s)
            S_PREAMBLE:          last_idx = CNT_W'(PREAMBLE_LEN - 1);
            S_START, S_OPCODE,
            S_TA:                last_idx = CNT_W'(1);
            S_PHYAD, S_REGAD:    last_idx = CNT_W'(4);
            S_DATA:              last_idx = CNT_W'(15);
            default:             last_idx = '0;
        endcase
    endfunction

    assign accept    = i_req && !busy_q;
    assign tick      = (state_q != S_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick = tick && !mdc_q;
    assign fall_tick = tick && mdc_q;

    // Control and status registers, cleared by reset (also mid-frame).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            mdc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            rdata_q <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mdc_q   <= mdc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    // Frame contents and receive shifter; only meaningful inside a frame.
    always_ff @(posedge i_clk) begin
        rw_q <= rw_d;
        sr_q <= sr_d;
        rx_q <= rx_d;
    end

    // Next state: each field advances after its last bit's MDC falling edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (accept) state_d = S_PREAMBLE;
        end else if (fall_tick) begin
            if (cnt_q == last_idx(state_q)) begin
                cnt_d = '0;
                case (state_q)
                    S_PREAMBLE: state_d = S_START;
                    S_START:    state_d = S_OPCODE;
                    S_OPCODE:   state_d = S_PHYAD;
                    S_PHYAD:    state_d = S_REGAD;
                    S_REGAD:    state_d = S_TA;
                    S_TA:       state_d = S_DATA;
                    default:    state_d = S_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs: MDC divider, pad drive on falling ticks, sampling on rising ticks.
    always_comb begin
        div_d   = div_q;
        mdc_d   = mdc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nack_d  = nack_q;
        rdata_d = rdata_q;
        out_d   = out_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        sr_d    = sr_q;
        rx_d    = rx_q;

        if (accept) begin
            // The acceptance cycle counts as divider cycle 0, so the final
            // MDC fall lands exactly 2*CLK_DIV*bits cycles after acceptance.
            div_d  = DIV_W'(1);
            busy_d = 1'b1;
            nack_d = 1'b0;
            out_d  = 1'b1;
            oe_d   = 1'b1;
            rw_d   = i_rw;
            sr_d   = {2'b01, (i_rw ? 2'b10 : 2'b01), i_phy_addr, i_reg_addr,
                      (i_rw ? 2'b11 : 2'b10), (i_rw ? 16'hFFFF : i_wdata)};
        end else if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end else if (done_q) begin
            busy_d = 1'b0;
        end

        if (tick) mdc_d = !mdc_q;

        if (rise_tick && rw_q) begin
            if (state_q == S_TA && cnt_q == CNT_W'(1)) nack_d = i_mdio_in;
            if (state_q == S_DATA) rx_d = {rx_q[14:0], i_mdio_in};
        end

        if (fall_tick) begin
            if (state_q != S_PREAMBLE) sr_d = {sr_q[30:0], 1'b1};
            oe_d = (state_d != S_IDLE) && !(rw_q && (state_d == S_TA || state_d == S_DATA));
            if (state_d == S_IDLE || state_d == S_PREAMBLE)
                out_d = 1'b1;
            else
                out_d = (state_q == S_PREAMBLE) ? sr_q[31] : sr_q[30];
            if (state_d == S_IDLE) begin
                done_d = 1'b1;
                if (rw_q) rdata_d = rx_q;
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rdata    = rdata_q;
    assign o_nack     = nack_q;
    assign o_mdc      = mdc_q;
    assign o_mdio_out = out_q;
    assign o_mdio_oe  = oe_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Self-checking bench for mdio_master_ctrl (CLK_DIV=2, PREAMBLE_LEN=32).
module tb_mdio_master_ctrl;

    localparam int CLK_DIV   = 2;
    localparam int PRE_LEN   = 32;
    localparam int FRAME_CYC = 2 * CLK_DIV * (PRE_LEN + 32);

    logic        clk = 1'b0;
    logic        i_reset, i_req, i_rw, i_mdio_in;
    logic [4:0]  i_phy_addr, i_reg_addr;
    logic [15:0] i_wdata;
    logic        o_busy, o_done, o_nack, o_mdc, o_mdio_out, o_mdio_oe;
    logic [15:0] o_rdata;

    mdio_master_ctrl #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PRE_LEN)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_rw       (i_rw),
        .i_phy_addr (i_phy_addr),
        .i_reg_addr (i_reg_addr),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_nack     (o_nack),
        .o_mdc      (o_mdc),
        .o_mdio_out (o_mdio_out),
        .o_mdio_oe  (o_mdio_oe),
        .i_mdio_in  (i_mdio_in)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_rd; logic [15:0] rdata; logic nack; int acc; } res_t;
    typedef struct { logic oe; logic out; logic care; } bit_t;

    res_t  results[$];
    bit_t  bits[$];
    int    n_cmp = 0, n_err = 0;
    int    cyc = 0, idx = 0, done_cnt = 0;
    logic  mdc_prev = 1'b0;
    logic  phy_on = 1'b0, phy_bit;
    logic [15:0] phy_data = '0, last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // PHY model: high-Z (reads 1) until the second TA bit, then 0, then data MSB first.
    always_comb begin
        if (idx == 47)                    phy_bit = 1'b0;
        else if (idx >= 48 && idx <= 63)  phy_bit = phy_data[4'(63 - idx)];
        else                              phy_bit = 1'b1;
    end
    assign i_mdio_in = phy_on ? phy_bit : 1'b1;

    // Queue the expected results and pad bits of a frame accepted in cycle acc.
    task automatic push_frame(input logic rw, input logic [4:0] phy, input logic [4:0] rg,
                              input logic [15:0] wd, input logic pon, input logic [15:0] pdata,
                              input int acc);
        res_t r;
        bit_t b;
        logic [63:0] v;
        v = {32'hFFFF_FFFF, 2'b01, (rw ? 2'b10 : 2'b01), phy, rg, 2'b10, (rw ? 16'h0000 : wd)};
        for (int i = 0; i < 64; i++) begin
            b.oe   = !(rw && i >= 46);
            b.out  = v[63 - i];
            b.care = b.oe;
            bits.push_back(b);
        end
        r.is_rd = rw;
        r.rdata = rw ? (pon ? pdata : 16'hFFFF) : last_rdata;
        r.nack  = rw && !pon;
        r.acc   = acc;
        if (rw) last_rdata = r.rdata;
        results.push_back(r);
    endtask

    // Monitor: checks pad bits on every MDC rise and results on every o_done.
    always @(negedge clk) begin
        bit_t b;
        res_t r;
        if (!mdc_prev && o_mdc) begin
            check("mdc_rise_expected", bits.size() > 0, 1);
            if (bits.size() > 0) begin
                b = bits.pop_front();
                check($sformatf("oe_bit%0d", idx), o_mdio_oe, b.oe);
                if (b.care) check($sformatf("mdio_bit%0d", idx), o_mdio_out, b.out);
            end
        end
        if (!o_busy) idx = 0;
        else if (mdc_prev && !o_mdc) idx++;
        if (o_done) begin
            done_cnt++;
            check("done_expected", results.size() > 0, 1);
            if (results.size() > 0) begin
                r = results.pop_front();
                check("done_latency", cyc - r.acc, FRAME_CYC);
                check("done_rdata", o_rdata, r.rdata);
                check("done_nack", o_nack, r.nack);
                check("done_mdc", o_mdc, 0);
                check("done_oe", o_mdio_oe, 0);
                check("done_busy", o_busy, 1);
            end
        end
        mdc_prev = o_mdc;
    end

    task automatic start_req(input logic rw, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd, input logic pon, input logic [15:0] pdata);
        int n = 0;
        @(negedge clk);
        while (o_busy && n < 2000) begin @(negedge clk); n++; end
        check("idle_before_req", o_busy, 0);
        i_rw = rw; i_phy_addr = phy; i_reg_addr = rg; i_wdata = wd;
        phy_on = pon; phy_data = pdata;
        i_req = 1'b1;
        push_frame(rw, phy, rg, wd, pon, pdata, cyc);
        @(negedge clk);
        i_req = 1'b0;
        check("accepted", o_busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (results.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        check("frame_finished", results.size(), 0);
        check("bits_consumed", bits.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, base, acc;
        i_reset = 1'b1; i_req = 1'b0; i_rw = 1'b0;
        i_phy_addr = '0; i_reg_addr = '0; i_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_nack", o_nack, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_mdc", o_mdc, 0);
        check("rst_mdio_out", o_mdio_out, 1);
        check("rst_oe", o_mdio_oe, 0);
        i_reset = 1'b0;

        // Write phy=1 reg=4 data=A5A5
        start_req(1'b0, 5'd1, 5'h04, 16'hA5A5, 1'b0, 16'h0000);
        wait_idle();

        // Read with a responding PHY
        start_req(1'b1, 5'd3, 5'h02, 16'h0000, 1'b1, 16'h1234);
        wait_idle();

        // Read with no PHY (pad pulled high)
        start_req(1'b1, 5'd7, 5'h11, 16'h0000, 1'b0, 16'h0000);
        wait_idle();

        // Requests during a frame are ignored
        start_req(1'b0, 5'd5, 5'h07, 16'h3C5A, 1'b0, 16'h0000);
        acc = results[0].acc;
        while (cyc < acc + 10) @(negedge clk);
        i_rw = 1'b1; i_phy_addr = 5'h1F; i_reg_addr = 5'h1E; i_wdata = 16'h0000; i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        while (cyc < acc + 100) @(negedge clk);
        i_rw = 1'b1; i_phy_addr = 5'h0A; i_reg_addr = 5'h15; i_wdata = 16'hFFFF; i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
        base = done_cnt;
        wait_idle();
        repeat (20) @(negedge clk);
        check("single_done", done_cnt - base, 1);

        // Reset during a write
        start_req(1'b0, 5'd9, 5'h03, 16'h5555, 1'b0, 16'h0000);
        acc = results[0].acc;
        while (cyc < acc + 50) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        results.delete();
        bits.delete();
        last_rdata = '0;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_nack", o_nack, 0);
        check("abort_rdata", o_rdata, 0);
        check("abort_mdc", o_mdc, 0);
        check("abort_mdio_out", o_mdio_out, 1);
        check("abort_oe", o_mdio_oe, 0);
        base = done_cnt;
        repeat (300) @(negedge clk);
        check("abort_no_done", done_cnt, base);
        check("abort_mdc_still", o_mdc, 0);

        start_req(1'b0, 5'd2, 5'h1F, 16'hC3C3, 1'b0, 16'h0000);
        wait_idle();

        // i_req held high: done-cycle request ignored, next cycle accepted
        @(negedge clk);
        i_rw = 1'b0; i_phy_addr = 5'd4; i_reg_addr = 5'd9; i_wdata = 16'h0F0F; i_req = 1'b1;
        push_frame(1'b0, 5'd4, 5'd9, 16'h0F0F, 1'b0, 16'h0000, cyc);
        got = 0;
        for (int n = 0; n < 2000 && got == 0; n++) begin
            @(negedge clk);
            if (o_done) got = 1;
        end
        check("held_first_done", got, 1);
        i_wdata = 16'hF0F0;
        push_frame(1'b0, 5'd4, 5'd9, 16'hF0F0, 1'b0, 16'h0000, cyc + 1);
        @(negedge clk);
        check("held_gap_idle", o_busy, 0);
        @(negedge clk);
        check("held_second_accept", o_busy, 1);
        i_req = 1'b0;
        wait_idle();
        check("final_nack", o_nack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdio_master_ctrl.md
MDIO_MASTER_CTRL -- requirements
Module: mdio_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10: i_clk cycles per MDC half-period; legal values are 2 or greater.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32: number of preamble '1' bits per frame.
REQ-003 i_clk  in  1  system clock; all logic on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  transaction request, sampled only while o_busy=0.
REQ-006 i_rw  in  1  transaction type: 1 = read, 0 = write.
REQ-007 i_phy_addr  in  5  target PHY address.
REQ-008 i_reg_addr  in  5  target register address.
REQ-009 i_wdata  in  16  write data.
REQ-010 o_busy  out  1  frame in progress.
REQ-011 o_done  out  1  one-cycle completion pulse.
REQ-012 o_rdata  out  16  read data, valid from o_done onward, held until the next read completes.
REQ-013 o_nack  out  1  read had no PHY response, valid with o_done.
REQ-014 o_mdc  out  1  MDIO management clock.
REQ-015 o_mdio_out  out  1  serial data to the pad.
REQ-016 o_mdio_oe  out  1  pad drive enable: 1 = drive, 0 = release.
REQ-017 i_mdio_in  in  1  serial data from the pad, already synchronised.

Function
REQ-018 SHALL accept a request when i_req=1 and o_busy=0, registering i_rw, i_phy_addr, i_reg_addr and i_wdata in that cycle; o_busy SHALL be 1 from the next cycle.
REQ-019 SHALL ignore i_req and all request inputs while o_busy=1.
REQ-020 Idle levels SHALL be o_mdc=0 and o_mdio_oe=0.
REQ-021 MDC SHALL run only while busy: a divider counts 0..CLK_DIV-1, toggles o_mdc at terminal count, and gives a period of 2*CLK_DIV cycles.
REQ-022 SHALL update o_mdio_out/o_mdio_oe on MDC falling-edge ticks and sample i_mdio_in on MDC rising-edge ticks.
REQ-023 The FSM SHALL have states IDLE -> PREAMBLE -> START -> OPCODE -> PHYAD -> REGAD -> TA -> DATA -> IDLE, each advancing after its bit count completes.
REQ-024 Bit sequence: PREAMBLE_LEN x '1', start "01", opcode "10" for read or "01" for write, phy addr then reg addr (5 bits each, MSB first), TA, then 16 data bits MSB first.
REQ-025 Write TA SHALL drive "10".
REQ-026 Read TA and DATA SHALL hold o_mdio_oe=0; the second TA bit is sampled, and a sampled 1 sets o_nack=1.
REQ-027 Read data bits SHALL shift into o_rdata MSB first.
REQ-028 o_rdata SHALL be updated regardless of o_nack; with no PHY present it reads 0xFFFF.
REQ-029 o_done SHALL pulse in the cycle o_busy falls, exactly 2*CLK_DIV*(PREAMBLE_LEN+32) cycles after the acceptance cycle.
REQ-030 In the o_done cycle: o_mdc=0 and o_mdio_oe=0.
REQ-031 A request presented in the o_done cycle SHALL NOT be accepted, because o_busy is still 1 in that cycle.
REQ-032 A request presented in the following cycle SHALL be accepted, so the minimum gap between frames is 1 cycle.
REQ-033 o_nack SHALL be cleared on acceptance of each new request; it is always 0 after a write.

Reset
REQ-034 On i_reset, including mid-frame: state=IDLE, divider=0, o_busy=0, o_done=0, o_nack=0, o_rdata=0, o_mdc=0, o_mdio_out=1, o_mdio_oe=0.
REQ-035 A frame aborted by reset SHALL produce no o_done pulse and no further MDC edges.

Verification (CLK_DIV=2, PREAMBLE_LEN=32)
REQ-036 Write phy=1, reg=0x04, data=0xA5A5 -> sampled on MDC rising edges: 32x1, 01, 01, 00001, 00100, 10, 1010010110100101; o_done exactly 256 cycles after acceptance; o_mdio_oe=1 for the whole frame.
REQ-037 Read phy=3, reg=0x02, with a PHY model driving TA bit 2 = 0 and data 0x1234 -> o_rdata=0x1234, o_nack=0 at o_done; o_mdio_oe=0 from TA start.
REQ-038 Read with i_mdio_in tied to 1 -> o_rdata=0xFFFF, o_nack=1 at o_done.
REQ-039 i_req pulsed at cycles 10 and 100 after an accepted request, with changed addresses -> no effect on the frame; exactly one o_done.
REQ-040 i_reset asserted at cycle 50 of a write -> all outputs at reset values the next cycle, no o_done; a new request after release completes normally.
REQ-041 i_req held high with a write -> request in the o_done cycle ignored, next cycle accepted; two complete frames with a 1-cycle gap.
